// File: rtl/alu_add_pipe.sv
// Two-stage pipelined add/subtract unit around a 4-bit-block carry-select adder.
// S1 registers decoded operands, S2 registers sum, carry-out and status flags.

module Carry_Select #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout
);
  localparam int NBLK = WIDTH / 4;

  logic [NBLK:0] carry_s;

  assign carry_s[0] = i_cin;

  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [4:0] sum0_s;
    logic [4:0] sum1_s;
    // Each block precomputes both carry-in cases and the ripple only picks one.
    assign sum0_s = {1'b0, i_a[g*4 +: 4]} + {1'b0, i_b[g*4 +: 4]};
    assign sum1_s = {1'b0, i_a[g*4 +: 4]} + {1'b0, i_b[g*4 +: 4]} + 5'd1;
    assign o_s[g*4 +: 4] = carry_s[g] ? sum1_s[3:0] : sum0_s[3:0];
    assign carry_s[g+1]  = carry_s[g] ? sum1_s[4]   : sum0_s[4];
  end

  assign o_cout = carry_s[NBLK];
endmodule

module alu_add_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic [1:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_neg
);
  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("alu_add_pipe: WIDTH must be a multiple of 4 and at least 4");
  end

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_eff_r;
  logic             cin_eff_r;
  logic             s1_valid_r;

  logic [WIDTH-1:0] b_eff_s;
  logic             cin_eff_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic             ovf_s;
  logic             s2_adv_s;
  logic             s1_to_s2_s;
  logic             in_xfer_s;

  // Handshake: o_ready depends on i_ready and registered state only.
  assign s2_adv_s   = !o_valid || i_ready;
  assign s1_to_s2_s = s1_valid_r && s2_adv_s;
  assign o_ready    = !s1_valid_r || s2_adv_s;
  assign in_xfer_s  = i_valid && o_ready;

  // Operation decode into adder operand B and carry-in.
  always_comb begin
    b_eff_s   = i_b;
    cin_eff_s = 1'b0;
    case (i_op)
      OP_ADD: begin
        b_eff_s   = i_b;
        cin_eff_s = 1'b0;
      end
      OP_ADC: begin
        b_eff_s   = i_b;
        cin_eff_s = i_cin;
      end
      OP_SUB: begin
        b_eff_s   = ~i_b;
        cin_eff_s = 1'b1;
      end
      OP_SBB: begin
        b_eff_s   = ~i_b;
        cin_eff_s = i_cin;
      end
      default: begin
        b_eff_s   = i_b;
        cin_eff_s = 1'b0;
      end
    endcase
  end

  // S1 operand register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_r        <= {WIDTH{1'b0}};
      b_eff_r    <= {WIDTH{1'b0}};
      cin_eff_r  <= 1'b0;
      s1_valid_r <= 1'b0;
    end else if (in_xfer_s) begin
      a_r        <= i_a;
      b_eff_r    <= b_eff_s;
      cin_eff_r  <= cin_eff_s;
      s1_valid_r <= 1'b1;
    end else if (s1_to_s2_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  Carry_Select #(.WIDTH(WIDTH)) u_adder (
    .i_a    (a_r),
    .i_b    (b_eff_r),
    .i_cin  (cin_eff_r),
    .o_s    (sum_s),
    .o_cout (cout_s)
  );

  // Signed overflow: like-signed operands giving a result of the other sign.
  assign ovf_s = (a_r[WIDTH-1] == b_eff_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);

  // S2 result register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_s     <= {WIDTH{1'b0}};
      o_cout  <= 1'b0;
      o_ovf   <= 1'b0;
      o_zero  <= 1'b0;
      o_neg   <= 1'b0;
      o_valid <= 1'b0;
    end else if (s1_to_s2_s) begin
      o_s     <= sum_s;
      o_cout  <= cout_s;
      o_ovf   <= ovf_s;
      o_zero  <= (sum_s == {WIDTH{1'b0}});
      o_neg   <= sum_s[WIDTH-1];
      o_valid <= 1'b1;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule
